// File: rtl/tank_move_arbiter_if.sv
// Move-request / verdict bundle for tank_move_arbiter.
// master: the requesting side (move FSM plus wall table); drives the request, the latched-at-
//         acceptance positions and the wall rectangle addressed by wall_idx.
// slave:  the arbiter; returns busy/done, the verdict and the wall table address.
// Signals: req, dir, main_ver/main_hor, sub_ver/sub_hor, wall_idx, wall_top/bottom/left/right,
//          busy, done, move_ok, hit_src, hit_idx.
interface tank_move_arbiter_if #(
  parameter int unsigned NUM_WALLS = 10,
  parameter int unsigned POS_W     = 10
);
  localparam int unsigned IDX_W = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;

  logic             req;
  logic [1:0]       dir;
  logic [POS_W-1:0] main_ver;
  logic [POS_W-1:0] main_hor;
  logic [POS_W-1:0] sub_ver;
  logic [POS_W-1:0] sub_hor;
  logic [IDX_W-1:0] wall_idx;
  logic [POS_W-1:0] wall_top;
  logic [POS_W-1:0] wall_bottom;
  logic [POS_W-1:0] wall_left;
  logic [POS_W-1:0] wall_right;
  logic             busy;
  logic             done;
  logic             move_ok;
  logic [1:0]       hit_src;
  logic [IDX_W-1:0] hit_idx;

  modport master (
    output req, dir, main_ver, main_hor, sub_ver, sub_hor,
    output wall_top, wall_bottom, wall_left, wall_right,
    input  wall_idx, busy, done, move_ok, hit_src, hit_idx
  );

  modport slave (
    input  req, dir, main_ver, main_hor, sub_ver, sub_hor,
    input  wall_top, wall_bottom, wall_left, wall_right,
    output wall_idx, busy, done, move_ok, hit_src, hit_idx
  );
endinterface

// File: rtl/tank_move_arbiter.sv
// Sequential collision checker for one tank move request.
// On acceptance the candidate box one STEP away is checked against the screen edges, then the
// wall table is scanned one wall per cycle, then (optionally) the other tank is checked. A single
// done pulse reports move_ok and the source/index of the first blocking hit.
// Ports: clk, rst_n (async, active-low), arb (tank_move_arbiter_if.slave).
// Config macro: SUB_TANK_CHECK_EN -- when defined, adds the TANK state testing against the
// other tank; when undefined the sub_* inputs are ignored and hit_src never reports 3.
module tank_move_arbiter #(
  parameter int unsigned NUM_WALLS = 10,
  parameter int unsigned POS_W     = 10,
  parameter int unsigned TANK_SIZE = 32,
  parameter int unsigned STEP      = 1,
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480
) (
  input logic                clk,
  input logic                rst_n,
  tank_move_arbiter_if.slave arb
);
  localparam int unsigned IDX_W = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WALLS - 1);

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_WALL   = 2'd1;
  localparam logic [1:0] SRC_SCREEN = 2'd2;
  localparam logic [1:0] SRC_TANK   = 2'd3;

  typedef enum logic [1:0] {StIdle, StScan, StTank, StDone} state_e;

  state_e           state_q, state_d;
  logic [POS_W:0]   cv_q, cv_d;
  logic [POS_W:0]   ch_q, ch_d;
  logic [IDX_W-1:0] wall_idx_q, wall_idx_d;
  logic [1:0]       hit_src_q, hit_src_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic             move_ok_q, move_ok_d;

  // Strict overlap: shared edges do not collide. All math in 32 bits so nothing wraps.
  function automatic logic overlap(input int unsigned v, input int unsigned h,
                                   input int unsigned top, input int unsigned bottom,
                                   input int unsigned left, input int unsigned right);
    return (v < bottom) && (v + TANK_SIZE > top) && (h < right) && (h + TANK_SIZE > left);
  endfunction

  int unsigned    ver, hor;
  logic           edge_hit;
  logic [POS_W:0] cand_v, cand_h;
  logic           wall_hit;

  always_comb begin
    ver      = 32'(arb.main_ver);
    hor      = 32'(arb.main_hor);
    edge_hit = 1'b0;
    cand_v   = (POS_W+1)'(ver);
    cand_h   = (POS_W+1)'(hor);
    unique case (arb.dir)
      2'd0: begin
        edge_hit = ver < STEP;
        cand_v   = (POS_W+1)'(ver - STEP);
      end
      2'd1: begin
        edge_hit = ver + STEP + TANK_SIZE > SCREEN_H;
        cand_v   = (POS_W+1)'(ver + STEP);
      end
      2'd2: begin
        edge_hit = hor < STEP;
        cand_h   = (POS_W+1)'(hor - STEP);
      end
      default: begin
        edge_hit = hor + STEP + TANK_SIZE > SCREEN_W;
        cand_h   = (POS_W+1)'(hor + STEP);
      end
    endcase
  end

  assign wall_hit = overlap(32'(cv_q), 32'(ch_q), 32'(arb.wall_top), 32'(arb.wall_bottom),
                            32'(arb.wall_left), 32'(arb.wall_right));

`ifdef SUB_TANK_CHECK_EN
  logic [POS_W-1:0] sub_ver_q, sub_hor_q;
  logic             tank_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_ver_q <= '0;
      sub_hor_q <= '0;
    end else if (state_q == StIdle && arb.req) begin
      sub_ver_q <= arb.sub_ver;
      sub_hor_q <= arb.sub_hor;
    end
  end

  assign tank_hit = overlap(32'(cv_q), 32'(ch_q), 32'(sub_ver_q), 32'(sub_ver_q) + TANK_SIZE,
                            32'(sub_hor_q), 32'(sub_hor_q) + TANK_SIZE);
`else
  logic unused_sub;
  assign unused_sub = ^{arb.sub_ver, arb.sub_hor};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_q       <= '0;
      ch_q       <= '0;
      wall_idx_q <= '0;
      hit_src_q  <= SRC_NONE;
      hit_idx_q  <= '0;
      move_ok_q  <= 1'b0;
    end else begin
      cv_q       <= cv_d;
      ch_q       <= ch_d;
      wall_idx_q <= wall_idx_d;
      hit_src_q  <= hit_src_d;
      hit_idx_q  <= hit_idx_d;
      move_ok_q  <= move_ok_d;
    end
  end

  // Next state and datapath; move_ok is set on the transition that reaches DONE clean.
  always_comb begin
    state_d    = state_q;
    cv_d       = cv_q;
    ch_d       = ch_q;
    wall_idx_d = wall_idx_q;
    hit_src_d  = hit_src_q;
    hit_idx_d  = hit_idx_q;
    move_ok_d  = move_ok_q;
    unique case (state_q)
      StIdle: begin
        if (arb.req) begin
          cv_d       = cand_v;
          ch_d       = cand_h;
          wall_idx_d = '0;
          hit_idx_d  = '0;
          move_ok_d  = 1'b0;
          if (edge_hit) begin
            hit_src_d = SRC_SCREEN;
            state_d   = StDone;
          end else begin
            hit_src_d = SRC_NONE;
            state_d   = StScan;
          end
        end
      end
      StScan: begin
        if (wall_hit) begin
          hit_src_d = SRC_WALL;
          hit_idx_d = wall_idx_q;
          state_d   = StDone;
        end else if (wall_idx_q == LAST_IDX) begin
`ifdef SUB_TANK_CHECK_EN
          state_d   = StTank;
`else
          move_ok_d = 1'b1;
          state_d   = StDone;
`endif
        end else begin
          wall_idx_d = wall_idx_q + IDX_W'(1);
        end
      end
`ifdef SUB_TANK_CHECK_EN
      StTank: begin
        if (tank_hit) hit_src_d = SRC_TANK;
        else          move_ok_d = 1'b1;
        state_d = StDone;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    arb.busy     = (state_q != StIdle);
    arb.done     = (state_q == StDone);
    arb.wall_idx = wall_idx_q;
    arb.move_ok  = move_ok_q;
    arb.hit_src  = hit_src_q;
    arb.hit_idx  = hit_idx_q;
  end
endmodule

// File: tb/tb_tank_move_arbiter.sv
// Directed bench for tank_move_arbiter: wall/edge/tank verdicts, latency, hold, reset, req held.
module tb_tank_move_arbiter;
  localparam int unsigned NW = 10;
  localparam int unsigned PW = 10;
`ifdef SUB_TANK_CHECK_EN
  localparam int CLEAN_LAT = 12;
  localparam int TANK_LAT  = 12;
  localparam int TANK_OK   = 0;
  localparam int TANK_SRC  = 3;
`else
  localparam int CLEAN_LAT = 11;
  localparam int TANK_LAT  = 11;
  localparam int TANK_OK   = 1;
  localparam int TANK_SRC  = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tank_move_arbiter_if #(.NUM_WALLS(NW), .POS_W(PW)) intf ();

  tank_move_arbiter #(
    .NUM_WALLS(NW), .POS_W(PW), .TANK_SIZE(32), .STEP(1), .SCREEN_W(640), .SCREEN_H(480)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .arb  (intf)
  );

  // Wall 0 from the test plan; walls 1..9 are 10x20 boxes at rows 300..320, cols 300+30j.
  logic [PW-1:0] wt[NW], wb[NW], wl[NW], wr[NW];
  initial begin
    wt[0] = 10'd76; wb[0] = 10'd107; wl[0] = 10'd94; wr[0] = 10'd357;
    for (int j = 1; j < NW; j++) begin
      wt[j] = 10'd300;
      wb[j] = 10'd320;
      wl[j] = PW'(300 + 30 * j);
      wr[j] = PW'(310 + 30 * j);
    end
  end

  always_comb begin
    intf.wall_top    = wt[intf.wall_idx];
    intf.wall_bottom = wb[intf.wall_idx];
    intf.wall_left   = wl[intf.wall_idx];
    intf.wall_right  = wr[intf.wall_idx];
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one request; lat is the cycle (acceptance = 0) in which done is seen, -1 on timeout.
  task automatic do_req(input logic [1:0] d, input int mv, input int mh, input int sv,
                        input int sh, output int lat, output int busy1);
    @(negedge clk);
    intf.dir      = d;
    intf.main_ver = PW'(mv);
    intf.main_hor = PW'(mh);
    intf.sub_ver  = PW'(sv);
    intf.sub_hor  = PW'(sh);
    intf.req      = 1'b1;
    @(posedge clk);
    #1 intf.req = 1'b0;
    // Scribble positions to show they were latched.
    intf.main_ver = 10'd0;
    intf.main_hor = 10'd0;
    intf.sub_ver  = 10'd0;
    intf.sub_hor  = 10'd0;
    lat   = -1;
    busy1 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) busy1 = int'(intf.busy);
      if (intf.done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_case(input string tag, input logic [1:0] d, input int mv, input int mh,
                          input int sv, input int sh, input int e_lat, input int e_ok,
                          input int e_src, input int e_idx);
    int lat, b1;
    do_req(d, mv, mh, sv, sh, lat, b1);
    check_eq({tag, "_lat"}, lat, e_lat);
    check_eq({tag, "_busy1"}, b1, 1);
    check_eq({tag, "_ok"}, int'(intf.move_ok), e_ok);
    check_eq({tag, "_src"}, int'(intf.hit_src), e_src);
    check_eq({tag, "_idx"}, int'(intf.hit_idx), e_idx);
  endtask

  initial begin
    int prev_done, last_pulse, pulses, gap_bad, overlap_bad;
    rst_n         = 1'b0;
    intf.req      = 1'b0;
    intf.dir      = 2'd0;
    intf.main_ver = '0;
    intf.main_hor = '0;
    intf.sub_ver  = '0;
    intf.sub_hor  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", int'(intf.busy), 0);
    check_eq("rst_done", int'(intf.done), 0);
    check_eq("rst_ok", int'(intf.move_ok), 0);
    check_eq("rst_src", int'(intf.hit_src), 0);
    check_eq("rst_idx", int'(intf.hit_idx), 0);
    check_eq("rst_widx", int'(intf.wall_idx), 0);
    rst_n = 1'b1;

    // Other tank parked at rows 400..432, cols 600..632 unless a case moves it.
    run_case("wall0_hit", 2'd1, 44, 100, 400, 600, 2, 0, 1, 0);
    run_case("wall0_touch", 2'd1, 43, 100, 400, 600, CLEAN_LAT, 1, 0, 0);
    run_case("edge_up", 2'd0, 0, 100, 400, 600, 1, 0, 2, 0);
    check_eq("edge_up_widx", int'(intf.wall_idx), 0);
    run_case("wall5_hit", 2'd1, 289, 440, 400, 600, 7, 0, 1, 5);
    repeat (3) @(negedge clk);
    check_eq("hold_ok", int'(intf.move_ok), 0);
    check_eq("hold_src", int'(intf.hit_src), 1);
    check_eq("hold_idx", int'(intf.hit_idx), 5);
    check_eq("hold_done", int'(intf.done), 0);
    run_case("right_fit", 2'd3, 0, 607, 400, 600, CLEAN_LAT, 1, 0, 0);
    run_case("right_edge", 2'd3, 0, 608, 400, 600, 1, 0, 2, 0);
    run_case("down_fit", 2'd1, 447, 0, 400, 600, CLEAN_LAT, 1, 0, 0);
    run_case("down_edge", 2'd1, 448, 0, 400, 600, 1, 0, 2, 0);
    run_case("left_edge", 2'd2, 0, 0, 400, 600, 1, 0, 2, 0);
    run_case("left_fit", 2'd2, 0, 1, 400, 600, CLEAN_LAT, 1, 0, 0);
    run_case("tank_hit", 2'd3, 200, 8, 200, 40, TANK_LAT, TANK_OK, TANK_SRC, 0);
    run_case("tank_touch", 2'd3, 200, 7, 200, 40, CLEAN_LAT, 1, 0, 0);

    // Asynchronous reset in cycle 5 of a clean scan.
    @(negedge clk);
    intf.dir = 2'd1; intf.main_ver = 10'd43; intf.main_hor = 10'd100;
    intf.sub_ver = 10'd400; intf.sub_hor = 10'd600;
    intf.req = 1'b1;
    @(posedge clk);
    #1 intf.req = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", int'(intf.busy), 0);
    check_eq("midrst_done", int'(intf.done), 0);
    check_eq("midrst_widx", int'(intf.wall_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_case("after_rst", 2'd1, 44, 100, 400, 600, 2, 0, 1, 0);

    // req held high: wall-0 hit repeats with done every 3 cycles.
    @(negedge clk);
    intf.dir = 2'd1; intf.main_ver = 10'd44; intf.main_hor = 10'd100;
    intf.req = 1'b1;
    prev_done = 0; last_pulse = -1; pulses = 0; gap_bad = 0; overlap_bad = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (intf.done) begin
        if (prev_done != 0) overlap_bad++;
        if (last_pulse >= 0 && n - last_pulse != 3) gap_bad++;
        if (last_pulse < 0 && n != 2) gap_bad++;
        last_pulse = n;
        pulses++;
      end
      prev_done = int'(intf.done);
    end
    intf.req = 1'b0;
    check_eq("hold_req_pulses", pulses, 10);
    check_eq("hold_req_gap", gap_bad, 0);
    check_eq("hold_req_overlap", overlap_bad, 0);
    repeat (5) @(negedge clk);
    check_eq("idle_busy", int'(intf.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
